// File: rtl/sau_odd_pipe.sv
// rtl/sau_odd_pipe.sv - two-stage shift-add multiplier for the DCT-II odd-part coefficients
// Mode 0 yields {83,36}X, mode 1 yields {89,75,50,18}X; valid/ready flow control, no skid buffer.
module sau_odd_pipe #(
  parameter int IN_W  = 20,
  parameter int OUT_W = IN_W + 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic signed [IN_W-1:0]  in_x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_mode,
  output logic signed [OUT_W-1:0] y0,
  output logic signed [OUT_W-1:0] y1,
  output logic signed [OUT_W-1:0] y2,
  output logic signed [OUT_W-1:0] y3
);

  logic                    s1_v, s2_v, s2_adv;
  logic                    s1_mode;
  logic signed [OUT_W-1:0] s1_x, s1_p64_16, s1_p2_1, s1_p8_1, s1_p32_16, s1_p16_2;

  logic signed [OUT_W-1:0] xe;
  logic signed [OUT_W-1:0] p64_16_d, p2_1_d, p8_1_d, p32_16_d, p16_2_d;
  logic signed [OUT_W-1:0] y0_d, y1_d, y2_d, y3_d;

  assign s2_adv    = ~s2_v | out_ready;
  assign in_ready  = ~s1_v | s2_adv;
  assign out_valid = s2_v;

  // Widen before shifting so 64X cannot lose its sign bit.
  assign xe = {{(OUT_W-IN_W){in_x[IN_W-1]}}, in_x};

  assign p64_16_d = (xe <<< 6) + (xe <<< 4);
  assign p2_1_d   = (xe <<< 1) + xe;
  assign p8_1_d   = (xe <<< 3) + xe;
  assign p32_16_d = (xe <<< 5) + (xe <<< 4);
  assign p16_2_d  = (xe <<< 4) + (xe <<< 1);

  // 83=(64+16)+(2+1)  89=(64+16)+(8+1)  75=64+8+(2+1)  36=32+4  50=(32+16)+2  18=(16+2)
  assign y0_d = s1_mode ? (s1_p64_16 + s1_p8_1) : (s1_p64_16 + s1_p2_1);
  assign y1_d = s1_mode ? ((s1_x <<< 6) + (s1_x <<< 3) + s1_p2_1)
                        : ((s1_x <<< 5) + (s1_x <<< 2));
  assign y2_d = s1_mode ? (s1_p32_16 + (s1_x <<< 1)) : '0;
  assign y3_d = s1_mode ? s1_p16_2 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s1_mode   <= 1'b0;
      s1_x      <= '0;
      s1_p64_16 <= '0;
      s1_p2_1   <= '0;
      s1_p8_1   <= '0;
      s1_p32_16 <= '0;
      s1_p16_2  <= '0;
      s2_v      <= 1'b0;
      out_mode  <= 1'b0;
      y0        <= '0;
      y1        <= '0;
      y2        <= '0;
      y3        <= '0;
    end else begin
      if (s2_adv) begin
        s2_v     <= s1_v;
        out_mode <= s1_mode;
        y0       <= y0_d;
        y1       <= y1_d;
        y2       <= y2_d;
        y3       <= y3_d;
      end
      if (in_ready) begin
        s1_v      <= in_valid;
        s1_mode   <= in_mode;
        s1_x      <= xe;
        s1_p64_16 <= p64_16_d;
        s1_p2_1   <= p2_1_d;
        s1_p8_1   <= p8_1_d;
        s1_p32_16 <= p32_16_d;
        s1_p16_2  <= p16_2_d;
      end
    end
  end

endmodule
